// File: rtl/command_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : command_controller_pkg
//  Description : Shared definitions for the command controller. It holds the
//                request command bytes, the response codes sent back over
//                the UART, and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package command_controller_pkg;

    // Request command bytes
    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUM    = 8'h02;

    // Response code bytes (first byte of every 2-byte response)
    localparam logic [7:0] OK_STATUS  = 8'h07;
    localparam logic [7:0] HUM        = 8'h08;
    localparam logic [7:0] TEMP       = 8'h09;
    localparam logic [7:0] SENSOR_ERR = 8'h1F;
    localparam logic [7:0] BAD_CMD    = 8'hDF;
    localparam logic [7:0] BAD_ADDR   = 8'hEF;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WAIT_ADDR   = 4'd1,
        ST_DECODE      = 4'd2,
        ST_SENSOR_REQ  = 4'd3,
        ST_WAIT_SENSOR = 4'd4,
        ST_SEND_CODE   = 4'd5,
        ST_WAIT_CODE   = 4'd6,
        ST_SEND_VALUE  = 4'd7,
        ST_WAIT_VALUE  = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/command_controller_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_counter
//  Description : Saturating cycle counter with a run-time limit. While enabled
//                it counts up from zero and raises o_expired once the count
//                has reached i_limit_m1 (limit minus one). It stops at that
//                value and never wraps. i_clear returns the count to zero.
//  Ports       : clk         - clock
//                rst_n       - synchronous active-low reset
//                i_clear     - restart the count at zero
//                i_enable    - count this cycle
//                i_limit_m1  - terminal count (timeout length minus one)
//                o_expired   - count has reached the terminal value
//  Revision    : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit_m1,
    output logic             o_expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q < i_limit_m1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_enable && (count_q >= i_limit_m1);

endmodule
`default_nettype wire

// File: rtl/command_controller.sv
`default_nettype none
// ============================================================================
//  Module      : command_controller
//  Description : Collects 2-byte requests (command, sensor address) from the
//                UART receiver, validates them, reads the addressed sensor
//                and returns a 2-byte response (code, value) through the UART
//                transmitter. The value byte of each finished response is
//                also shown on the seven-segment display.
//  Ports       : clock, reset        - clock, synchronous active-low reset
//                rx_done, rx_data    - received byte strobe and data
//                tx_busy, tx_done    - transmitter status
//                tx_start, tx_data   - transmit request and byte
//                sensor_request/address, sensor_done/error,
//                sensor_humidity/temperature - sensor read handshake
//                display_value       - last response value byte
//                busy                - request in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module command_controller
    import command_controller_pkg::*;
#(
    parameter int unsigned NUM_SENSORS       = 32,
    parameter int unsigned INTERBYTE_TIMEOUT = 50000,
    parameter int unsigned SENSOR_TIMEOUT    = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       sensor_request,
    output logic [4:0] sensor_address,
    input  logic       sensor_done,
    input  logic       sensor_error,
    input  logic [7:0] sensor_humidity,
    input  logic [7:0] sensor_temperature,
    output logic [7:0] display_value,
    output logic       busy
);

    localparam int unsigned c_timer_max = (INTERBYTE_TIMEOUT > SENSOR_TIMEOUT) ?
                                          INTERBYTE_TIMEOUT : SENSOR_TIMEOUT;
    localparam int unsigned c_timer_w   = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;
    localparam logic [c_timer_w-1:0] c_ib_limit_m1  = c_timer_w'(INTERBYTE_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_sen_limit_m1 = c_timer_w'(SENSOR_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] code_q, code_d;
    logic [7:0] value_q, value_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       sensor_request_q, sensor_request_d;
    logic [4:0] sensor_address_q, sensor_address_d;
    logic [7:0] display_value_q, display_value_d;

    logic                 w_timer_en;
    logic [c_timer_w-1:0] w_timer_limit_m1;
    logic                 w_timer_expired;

    // One timer serves both waiting states; it restarts from zero whenever
    // the FSM is outside them, so each wait begins with a fresh count.
    assign w_timer_en       = (state_q == ST_WAIT_ADDR) || (state_q == ST_WAIT_SENSOR);
    assign w_timer_limit_m1 = (state_q == ST_WAIT_ADDR) ? c_ib_limit_m1 : c_sen_limit_m1;

    timeout_counter #(
        .WIDTH (c_timer_w)
    ) u_timeout (
        .clk        (clock),
        .rst_n      (reset),
        .i_clear    (!w_timer_en),
        .i_enable   (w_timer_en),
        .i_limit_m1 (w_timer_limit_m1),
        .o_expired  (w_timer_expired)
    );

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        addr_d           = addr_q;
        code_d           = code_q;
        value_d          = value_q;
        tx_start_d       = 1'b0;
        tx_data_d        = tx_data_q;
        sensor_request_d = 1'b0;
        sensor_address_d = sensor_address_q;
        display_value_d  = display_value_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    cmd_d   = rx_data;
                    state_d = ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                // A byte arriving in the expiry cycle still counts.
                if (rx_done) begin
                    addr_d  = rx_data;
                    state_d = ST_DECODE;
                end else if (w_timer_expired) begin
                    cmd_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (cmd_q > CMD_HUM) begin
                    code_d  = BAD_CMD;
                    value_d = cmd_q;
                    state_d = ST_SEND_CODE;
                end else if ({24'd0, addr_q} >= NUM_SENSORS) begin
                    code_d  = BAD_ADDR;
                    value_d = addr_q;
                    state_d = ST_SEND_CODE;
                end else begin
                    // Request is raised here so the pulse coincides with SENSOR_REQ.
                    sensor_address_d = addr_q[4:0];
                    sensor_request_d = 1'b1;
                    state_d          = ST_SENSOR_REQ;
                end
            end
            ST_SENSOR_REQ: begin
                state_d = ST_WAIT_SENSOR;
            end
            ST_WAIT_SENSOR: begin
                // sensor_done is checked first so it wins over a same-cycle timeout.
                if (sensor_done) begin
                    state_d = ST_SEND_CODE;
                    if (sensor_error) begin
                        code_d  = SENSOR_ERR;
                        value_d = addr_q;
                    end else begin
                        case (cmd_q)
                            CMD_TEMP: begin
                                code_d  = TEMP;
                                value_d = sensor_temperature;
                            end
                            CMD_HUM: begin
                                code_d  = HUM;
                                value_d = sensor_humidity;
                            end
                            default: begin
                                code_d  = OK_STATUS;
                                value_d = addr_q;
                            end
                        endcase
                    end
                end else if (w_timer_expired) begin
                    code_d  = SENSOR_ERR;
                    value_d = addr_q;
                    state_d = ST_SEND_CODE;
                end
            end
            ST_SEND_CODE, ST_SEND_VALUE: begin
                // Launch is handled below once the transmitter is free.
            end
            ST_WAIT_CODE: begin
                // A tx_done coinciding with our own tx_start belongs to an
                // earlier frame and is ignored.
                if (tx_done && !tx_start_q) begin
                    state_d = ST_SEND_VALUE;
                end
            end
            ST_WAIT_VALUE: begin
                if (tx_done && !tx_start_q) begin
                    display_value_d = value_q;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx_start is registered, so a byte is launched on the edge that would
        // enter (or keep) a SEND state when the transmitter is already idle.
        // This keeps the response latency at one cycle after the decision.
        if ((state_d == ST_SEND_CODE) && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = code_d;
            state_d    = ST_WAIT_CODE;
        end else if ((state_d == ST_SEND_VALUE) && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = value_d;
            state_d    = ST_WAIT_VALUE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            cmd_q            <= '0;
            addr_q           <= '0;
            code_q           <= '0;
            value_q          <= '0;
            tx_start_q       <= 1'b0;
            tx_data_q        <= '0;
            sensor_request_q <= 1'b0;
            sensor_address_q <= '0;
            display_value_q  <= '0;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            addr_q           <= addr_d;
            code_q           <= code_d;
            value_q          <= value_d;
            tx_start_q       <= tx_start_d;
            tx_data_q        <= tx_data_d;
            sensor_request_q <= sensor_request_d;
            sensor_address_q <= sensor_address_d;
            display_value_q  <= display_value_d;
        end
    end

    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign sensor_request = sensor_request_q;
    assign sensor_address = sensor_address_q;
    assign display_value  = display_value_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_WAIT_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_command_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_command_controller
//  Description : Self-checking bench for command_controller. A request-level
//                model predicts the response bytes and sensor reads; a
//                monitor compares every tx_start and sensor_request against
//                it, and directed tests pin latencies and literal bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_command_controller;

    localparam int unsigned NUM_S = 32;
    localparam int unsigned IB_TO = 16;
    localparam int unsigned SN_TO = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sensor_request;
    logic [4:0] sensor_address;
    logic       sensor_done = 1'b0;
    logic       sensor_error = 1'b0;
    logic [7:0] sensor_humidity = 8'h00;
    logic [7:0] sensor_temperature = 8'h00;
    logic [7:0] display_value;
    logic       busy;

    // Bench-side transmitter and sensor behaviour knobs
    logic tx_active = 1'b0;
    logic hold_busy = 1'b0;
    logic tx_glitch = 1'b0;
    int   tx_len    = 3;
    int   sens_mode = 0;   // 0 ok, 1 error, 2 never answers
    int   sens_delay = 3;

    assign tx_busy = tx_active | hold_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int sens_done_cyc = 0;
    int rst_epoch = 0;

    logic [7:0] exp_tx[$];
    logic [4:0] exp_req[$];
    logic [7:0] tx_log[$];
    int         start_cycs[$];
    int         req_cycs[$];
    logic [7:0] exp_disp = 8'h00;

    command_controller #(
        .NUM_SENSORS       (NUM_S),
        .INTERBYTE_TIMEOUT (IB_TO),
        .SENSOR_TIMEOUT    (SN_TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .rx_done            (rx_done),
        .rx_data            (rx_data),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_start           (tx_start),
        .tx_data            (tx_data),
        .sensor_request     (sensor_request),
        .sensor_address     (sensor_address),
        .sensor_done        (sensor_done),
        .sensor_error       (sensor_error),
        .sensor_humidity    (sensor_humidity),
        .sensor_temperature (sensor_temperature),
        .display_value      (display_value),
        .busy               (busy)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Response predicted from the request and the sensor outcome
    // (outcome: 0 = good read, otherwise failed or timed-out read).
    function automatic logic [15:0] model_resp(input logic [7:0] cmd, input logic [7:0] addr,
                                               input int outcome, input logic [7:0] t,
                                               input logic [7:0] h);
        if (cmd > 8'h02)   return {8'hDF, cmd};
        if (addr >= NUM_S) return {8'hEF, addr};
        if (outcome != 0)  return {8'h1F, addr};
        if (cmd == 8'h01)  return {8'h09, t};
        if (cmd == 8'h02)  return {8'h08, h};
        return {8'h07, addr};
    endfunction

    // Monitor: every tx_start / sensor_request must match the model queues.
    initial forever begin
        @(negedge clock);
        if (tx_start) begin
            tx_log.push_back(tx_data);
            start_cycs.push_back(cyc);
            check("tx_start_expected", int'(exp_tx.size() > 0), 1);
            if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (sensor_request) begin
            req_cycs.push_back(cyc);
            check("sensor_request_expected", int'(exp_req.size() > 0), 1);
            if (exp_req.size() > 0) check("sensor_address", sensor_address, exp_req.pop_front());
        end
    end

    // Transmitter model: busy for tx_len cycles after tx_start, then tx_done.
    initial begin
        int cnt;
        int ep;
        logic [7:0] d;
        cnt = 0; ep = 0; d = 8'h00;
        forever begin
            @(negedge clock);
            tx_done = 1'b0;
            if (tx_active) begin
                cnt--;
                if (cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                    if (ep == rst_epoch) check("tx_data_hold", tx_data, d);
                end
            end else if (tx_start) begin
                tx_active = 1'b1;
                cnt = tx_len;
                ep  = rst_epoch;
                d   = tx_data;
                if (tx_glitch) tx_done = 1'b1;
            end
        end
    end

    // Sensor model: answers sens_delay cycles after the request.
    initial begin
        int cnt;
        bit pend;
        cnt = 0; pend = 1'b0;
        forever begin
            @(negedge clock);
            sensor_done  = 1'b0;
            sensor_error = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    pend          = 1'b0;
                    sensor_done   = 1'b1;
                    sensor_error  = (sens_mode == 1);
                    sens_done_cyc = cyc;
                end
            end else if (sensor_request && sens_mode != 2) begin
                pend = 1'b1;
                cnt  = sens_delay;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data     = b;
        rx_done     = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clock);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || exp_tx.size() != 0) && n < 3000);
        check("idle_reached", int'(n < 3000), 1);
    endtask

    task automatic expect_request(input logic [7:0] cmd, input logic [7:0] addr);
        logic [15:0] r;
        r = model_resp(cmd, addr, (sens_mode == 0) ? 0 : 1, sensor_temperature, sensor_humidity);
        exp_tx.push_back(r[15:8]);
        exp_tx.push_back(r[7:0]);
        exp_disp = r[7:0];
        if (cmd <= 8'h02 && addr < NUM_S) exp_req.push_back(addr[4:0]);
        tx_log.delete();
        start_cycs.delete();
        req_cycs.delete();
    endtask

    task automatic do_request(input logic [7:0] cmd, input logic [7:0] addr, input int gap);
        expect_request(cmd, addr);
        send_byte(cmd);
        repeat (gap) @(negedge clock);
        send_byte(addr);
        wait_idle();
        check("display_value", display_value, exp_disp);
        check("tx_byte_count", tx_log.size(), 2);
        check("req_outstanding", exp_req.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running, required done");
        $fatal(1);
    end

    initial begin
        int n;
        int rel;
        repeat (3) @(negedge clock);
        check("reset_tx_start", tx_start, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_sensor_request", sensor_request, 0);
        check("reset_sensor_address", sensor_address, 0);
        check("reset_display_value", display_value, 0);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        @(negedge clock);

        // Temperature read; tx_done glitches in each tx_start cycle must be ignored.
        sensor_temperature = 8'h19;
        sens_mode = 0; sens_delay = 3; tx_glitch = 1'b1;
        do_request(8'h01, 8'h03, 0);
        tx_glitch = 1'b0;
        check("temp_req_count", req_cycs.size(), 1);
        if (req_cycs.size() > 0) check("temp_req_latency", req_cycs[0] - last_rx_cyc, 2);
        if (tx_log.size() == 2) begin
            check("temp_code_lit", tx_log[0], 8'h09);
            check("temp_value_lit", tx_log[1], 8'h19);
            check("temp_done_to_start", start_cycs[0] - sens_done_cyc, 1);
            check("temp_code_value_gap", start_cycs[1] - start_cycs[0], tx_len + 1);
        end
        check("temp_display_lit", display_value, 8'h19);

        // Bad command
        do_request(8'h05, 8'h00, 0);
        check("badcmd_no_req", req_cycs.size(), 0);
        if (tx_log.size() == 2) begin
            check("badcmd_code_lit", tx_log[0], 8'hDF);
            check("badcmd_value_lit", tx_log[1], 8'h05);
            check("badcmd_latency", start_cycs[0] - last_rx_cyc, 2);
        end

        // Bad address, then the highest valid address
        do_request(8'h02, 8'h20, 0);
        if (tx_log.size() == 2) begin
            check("badaddr_code_lit", tx_log[0], 8'hEF);
            check("badaddr_value_lit", tx_log[1], 8'h20);
        end
        do_request(8'h00, 8'h1F, 0);
        check("status31_display_lit", display_value, 8'h1F);

        // Interbyte timeout: lone byte is dropped, following pair is fresh
        tx_log.delete();
        send_byte(8'h01);
        repeat (IB_TO) @(negedge clock);
        check("ib_timeout_no_tx", tx_log.size(), 0);
        check("ib_timeout_busy", busy, 0);
        sensor_humidity = 8'h37;
        do_request(8'h02, 8'h01, 0);
        if (tx_log.size() == 2) begin
            check("hum_code_lit", tx_log[0], 8'h08);
            check("hum_value_lit", tx_log[1], 8'h37);
        end
        // Address byte landing exactly in the expiry cycle is accepted
        do_request(8'h00, 8'h05, IB_TO - 2);

        // Sensor never answers
        sens_mode = 2;
        do_request(8'h01, 8'h04, 0);
        if (tx_log.size() == 2) begin
            check("sens_to_code_lit", tx_log[0], 8'h1F);
            check("sens_to_value_lit", tx_log[1], 8'h04);
            if (req_cycs.size() > 0) check("sens_to_latency", start_cycs[0] - req_cycs[0], SN_TO + 1);
        end
        // sensor_done in the expiry cycle wins
        sens_mode = 0; sens_delay = SN_TO; sensor_humidity = 8'h55;
        do_request(8'h02, 8'h06, 0);
        // Sensor reports an error
        sens_mode = 1; sens_delay = 2;
        do_request(8'h00, 8'h0A, 0);
        if (tx_log.size() == 2) check("sens_err_code_lit", tx_log[0], 8'h1F);
        sens_mode = 0; sens_delay = 3;

        // Back-pressure: tx_start withheld while tx_busy, extra byte ignored
        hold_busy = 1'b1;
        expect_request(8'h07, 8'h00);
        send_byte(8'h07);
        send_byte(8'h00);
        repeat (3) @(negedge clock);
        send_byte(8'h01);
        repeat (5) @(negedge clock);
        check("bp_start_withheld", start_cycs.size(), 0);
        hold_busy = 1'b0;
        rel = cyc;
        wait_idle();
        check("bp_release_latency", (start_cycs.size() > 0) ? start_cycs[0] - rel : -1, 1);
        check("bp_display", display_value, 8'h07);
        do_request(8'h00, 8'h02, 0);

        // Reset while waiting for the code byte to finish
        tx_len = 12;
        expect_request(8'h09, 8'h00);
        send_byte(8'h09);
        send_byte(8'h00);
        n = 0;
        while (start_cycs.size() == 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("rst_first_start_seen", start_cycs.size(), 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rst_epoch++;
        exp_tx.delete();
        exp_req.delete();
        @(negedge clock);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_sensor_request", sensor_request, 0);
        check("rst_sensor_address", sensor_address, 0);
        check("rst_display_value", display_value, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("rst_no_tx_after", start_cycs.size(), 1);
        check("rst_busy_after", busy, 0);
        tx_len = 3;

        // Recovery after reset
        sensor_temperature = 8'h42;
        do_request(8'h01, 8'h07, 0);
        check("recover_display_lit", display_value, 8'h42);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/command_controller.md
Name: command_controller

Overview:
- Sits between the UART receiver and the UART transmitter in the sensor top level.
- Assembles 2-byte requests (command, sensor address) from received bytes and validates them.
- Issues one read to the sensor interface, then streams a 2-byte response (code, value) to the transmitter.
- Also drives the byte shown on the seven-segment decoders.

Parameters:
NUM_SENSORS, 32, number of addressable sensors; valid addresses are 0..NUM_SENSORS-1
INTERBYTE_TIMEOUT, 50000, max cycles between command byte and address byte
SENSOR_TIMEOUT, 2000000, max cycles waiting for sensor_done after sensor_request

Ports:
clock  in  1  system clock (the divided clock at top level)
reset  in  1  synchronous, active-low reset
rx_done  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  transmitter is sending a frame
tx_done  in  1  one-cycle pulse: frame finished
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  8  byte to send; held stable from tx_start until tx_done
sensor_request  out  1  one-cycle pulse: start read of sensor_address
sensor_address  out  5  target sensor, held from request until sensor_done/timeout
sensor_done  in  1  one-cycle pulse: read complete
sensor_error  in  1  qualifies sensor_done: read failed
sensor_humidity  in  8  integer humidity, valid with sensor_done
sensor_temperature  in  8  integer temperature, valid with sensor_done
display_value  out  8  last response value byte, to seven-segment decoders
busy  out  1  high in every state except IDLE and WAIT_ADDR

Behaviour:
- Reset (reset==0 at a clock edge):
  - state IDLE; tx_start=0, tx_data=0, sensor_request=0, sensor_address=0, display_value=0, busy=0.
  - Timers and latched bytes are cleared.
- Reset mid-operation aborts everything. Any later tx_done/sensor_done is ignored while in IDLE.
- Commands: 0x00 status, 0x01 temperature, 0x02 humidity.
- Response codes (package constants):
  - OK_STATUS 0x07
  - HUM 0x08
  - TEMP 0x09
  - SENSOR_ERR 0x1F
  - BAD_CMD 0xDF
  - BAD_ADDR 0xEF
- FSM states and transitions:
  - IDLE: on rx_done, latch rx_data as cmd and go to WAIT_ADDR with the timer cleared.
  - WAIT_ADDR: timer counts each cycle.
    - rx_done: latch addr and go to DECODE.
    - Timer reaches INTERBYTE_TIMEOUT-1 with no byte: drop cmd, return to IDLE, send nothing.
    - rx_done in the same cycle as expiry: the byte is accepted.
  - DECODE (1 cycle), checks in priority order:
    - cmd > 0x02: code=BAD_CMD, value=cmd; go to SEND_CODE.
    - addr >= NUM_SENSORS: code=BAD_ADDR, value=addr; go to SEND_CODE.
    - Otherwise: sensor_address=addr[4:0]; go to SENSOR_REQ.
  - SENSOR_REQ (1 cycle): pulse sensor_request; go to WAIT_SENSOR with the timer cleared.
  - WAIT_SENSOR:
    - sensor_done with sensor_error=1: code=SENSOR_ERR, value=addr.
    - sensor_done with sensor_error=0 and cmd 0x00: code=OK_STATUS, value=addr.
    - sensor_done with sensor_error=0 and cmd 0x01: code=TEMP, value=sensor_temperature.
    - sensor_done with sensor_error=0 and cmd 0x02: code=HUM, value=sensor_humidity.
    - Timer reaches SENSOR_TIMEOUT-1: code=SENSOR_ERR, value=addr.
    - sensor_done wins over a simultaneous timeout.
    - Exit to SEND_CODE.
  - SEND_CODE: wait until tx_busy==0, then tx_data=code and pulse tx_start for 1 cycle; go to WAIT_CODE.
  - WAIT_CODE: on tx_done go to SEND_VALUE. A tx_done in the same cycle as tx_start is ignored.
  - SEND_VALUE, WAIT_VALUE: same as SEND_CODE/WAIT_CODE but with value. On tx_done, display_value=value and go to IDLE.
- display_value updates only on a completed 2-byte response; error responses update it too.
- rx_done arriving in DECODE through WAIT_VALUE is discarded; there is no queuing.
- Latency:
  - Final rx_done to sensor_request: 2 cycles (DECODE, SENSOR_REQ).
  - Bad request (final rx_done to first tx_start): 2 cycles if tx_busy=0.
  - sensor_done to tx_start: 1 cycle if tx_busy=0.
- Timers are sized to $clog2 of the largest timeout and saturate; they never wrap.

Decomposition:
- Shared package holds:
  - command constants CMD_STATUS/CMD_TEMP/CMD_HUM
  - the six response codes
  - the state enum
- One natural sub-module: timeout_counter (clear, enable, limit parameter, expired flag). It is instantiated once and shared by WAIT_ADDR and WAIT_SENSOR, because the two states are exclusive.

Test Plan:
- Temperature read: bytes 0x01, 0x03; sensor_done with temperature=0x19, error=0.
  - Expect sensor_request once with sensor_address=3.
  - Expect tx bytes 0x09 then 0x19; display_value=0x19.
- Bad command: bytes 0x05, 0x00.
  - Expect no sensor_request.
  - Expect tx bytes 0xDF, 0x05; tx_start 2 cycles after the second rx_done.
- Bad address: bytes 0x02, 0x20 (NUM_SENSORS=32).
  - Expect tx bytes 0xEF, 0x20.
- Interbyte timeout (INTERBYTE_TIMEOUT=16):
  - Byte 0x01 then nothing for 16 cycles: state returns to IDLE and no tx.
  - A following pair 0x02, 0x01 with humidity 0x37 yields 0x08, 0x37.
- Sensor timeout (SENSOR_TIMEOUT=100) with no sensor_done: tx bytes 0x1F, addr.
  - Also: sensor_done with error=1 gives the same response.
- Back-pressure and reset:
  - Hold tx_busy=1 through SEND_CODE: tx_start is withheld until release.
  - Extra rx_done while busy is ignored.
  - reset=0 during WAIT_CODE: outputs return to reset values; a later tx_done causes no tx_start.
